// File: rtl/anton_neopixel_stream_fsm.sv
// Self-sequencing NeoPixel serializer.
// Accepts whole pixels over a valid/ready handshake and emits the one-wire
// waveform from internal cycle/bit/channel counters. A latch (reset-low)
// period is inserted at the end of every frame.
//
// Handshake: a pixel is transferred on a rising clk7mhz edge where both
// pixelValid and pixelReady are high. pixelReady never depends on
// pixelValid. A producer may raise pixelValid at any time and must hold
// pixelData/pixelLast stable until the transfer edge.
module anton_neopixel_stream_fsm #(
    parameter int CHANNELS     = 3,
    parameter int PERIOD       = 8,
    parameter int T0H          = 2,
    parameter int T1H          = 5,
    parameter int RESET_CYCLES = 350
) (
    input  logic                  clk7mhz,
    input  logic                  syncReset,
    input  logic [CHANNELS*8-1:0] pixelData,
    input  logic                  pixelValid,
    input  logic                  pixelLast,
    output logic                  pixelReady,
    input  logic                  regCtrlRun,
    input  logic                  regCtrl32bit,
    output logic                  neoData,
    output logic                  busy,
    output logic                  frameDone,
    output logic                  underrun,
    output logic [1:0]            debugState
);

    localparam int WORD_W = CHANNELS * 8;
    localparam int CYC_W  = $clog2(PERIOD);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int LAT_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [CYC_W:0] T0H_C = (CYC_W + 1)'(T0H);
    localparam logic [CYC_W:0] T1H_C = (CYC_W + 1)'(T1H);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSMIT = 2'd1,
        LATCH    = 2'd2
    } stateT;

    stateT              state;
    logic [WORD_W-1:0]  shiftWord;
    logic               lastFlag;
    logic               abortFlag;
    logic [CYC_W-1:0]   cycleCnt;
    logic [2:0]         bitCnt;
    logic [CH_W-1:0]    chanCnt;
    logic [LAT_W-1:0]   latchCnt;

    logic               lastCycle;
    logic               lastBit;
    logic               lastChan;
    logic               finalPos;
    logic               transfer;
    logic [WORD_W-1:0]  loadWord;
    logic [CYC_W-1:0]   nextCycle;
    logic [2:0]         nextBitCnt;
    logic [CH_W-1:0]    nextChan;
    logic [CH_W+2:0]    nextIdx;
    logic               nextBitVal;
    logic               nextHigh;

    assign debugState = state;

    // Position decode and handshake: ready in IDLE, or in the very last cycle of a non-final pixel.
    always_comb begin
        lastCycle  = (cycleCnt == CYC_W'(PERIOD - 1));
        lastBit    = (bitCnt == 3'd7);
        lastChan   = (chanCnt == CH_W'(CHANNELS - 1));
        finalPos   = (state == TRANSMIT) && lastCycle && lastBit && lastChan;
        pixelReady = syncReset && regCtrlRun && ((state == IDLE) || (finalPos && !lastFlag));
        underrun   = syncReset && regCtrlRun && !pixelValid && finalPos && !lastFlag;
        transfer   = pixelValid && pixelReady;
    end

    // Word to load: raw bytes, or the packed BBGGGRRR byte expanded to MSB-aligned channels.
    always_comb begin
        loadWord = '0;
        if (regCtrl32bit) begin
            loadWord = pixelData;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                case (k)
                    0:       loadWord[k*8 +: 8] = {pixelData[5:3], 5'b00000};
                    1:       loadWord[k*8 +: 8] = {pixelData[2:0], 5'b00000};
                    2:       loadWord[k*8 +: 8] = {pixelData[7:6], 6'b000000};
                    default: loadWord[k*8 +: 8] = 8'h00;
                endcase
            end
        end
    end

    // Next serial position and the line level it produces (MSB of each channel first).
    always_comb begin
        nextCycle  = lastCycle ? '0 : cycleCnt + 1'b1;
        nextBitCnt = lastCycle ? bitCnt + 3'd1 : bitCnt;
        nextChan   = (lastCycle && lastBit) ? chanCnt + 1'b1 : chanCnt;
        nextIdx    = {nextChan, ~nextBitCnt};
        nextBitVal = shiftWord[nextIdx];
        nextHigh   = ({1'b0, nextCycle} < (nextBitVal ? T1H_C : T0H_C));
    end

    // Frame sequencer: IDLE -> TRANSMIT (pixels back to back) -> LATCH -> IDLE.
    always_ff @(posedge clk7mhz) begin
        if (!syncReset) begin
            state     <= IDLE;
            shiftWord <= '0;
            lastFlag  <= 1'b0;
            abortFlag <= 1'b0;
            cycleCnt  <= '0;
            bitCnt    <= '0;
            chanCnt   <= '0;
            latchCnt  <= '0;
            neoData   <= 1'b0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                IDLE: begin
                    neoData   <= 1'b0;
                    busy      <= 1'b0;
                    abortFlag <= 1'b0;
                    if (transfer) begin
                        shiftWord <= loadWord;
                        lastFlag  <= pixelLast;
                        cycleCnt  <= '0;
                        bitCnt    <= '0;
                        chanCnt   <= '0;
                        // Cycle 0 of any bit is high because T0H >= 1.
                        neoData   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= TRANSMIT;
                    end
                end
                TRANSMIT: begin
                    if (!regCtrlRun) begin
                        state     <= LATCH;
                        abortFlag <= 1'b1;
                        latchCnt  <= '0;
                        neoData   <= 1'b0;
                    end else if (finalPos) begin
                        if (transfer) begin
                            shiftWord <= loadWord;
                            lastFlag  <= pixelLast;
                            cycleCnt  <= '0;
                            bitCnt    <= '0;
                            chanCnt   <= '0;
                            neoData   <= 1'b1;
                        end else begin
                            state     <= LATCH;
                            abortFlag <= 1'b0;
                            latchCnt  <= '0;
                            neoData   <= 1'b0;
                        end
                    end else begin
                        cycleCnt <= nextCycle;
                        bitCnt   <= nextBitCnt;
                        chanCnt  <= nextChan;
                        neoData  <= nextHigh;
                    end
                end
                LATCH: begin
                    neoData <= 1'b0;
                    if (latchCnt == LAT_W'(RESET_CYCLES - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        frameDone <= !abortFlag;
                        latchCnt  <= '0;
                    end else begin
                        latchCnt <= latchCnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    neoData <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
